// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and types for the instruction-memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, HALT word default, bytes-per-word helper.
package imem_loader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_RECV  = RECV,
        ST_WRITE = WRITE,
        ST_DONE  = DONE
    } state_t;

    localparam int          NB_WIDTH_DEF      = 32;
    localparam int          NB_BYTE_DEF       = 8;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    function automatic int bytes_per_word(input int nb_width, input int nb_byte);
        return nb_width / nb_byte;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(NB_WIDTH_DEF, NB_BYTE_DEF);

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// byte_assembler: packs a byte stream into words, first byte lands in the MSBs.
// Latency: word register updates on the shift edge; word_ready is combinational with the last shift.
// Backpressure: none of its own; the caller only asserts shift_en on an accepted byte.
// Ports: clk/reset (sync, active-high), clear (restart a word), shift_en + byte_in (accepted byte),
//        word (assembled word), word_ready (this shift completes a word).
module byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int NB_WIDTH = 32,
    parameter int NB_BYTE  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                shift_en,
    input  logic [NB_BYTE-1:0]  byte_in,
    output logic [NB_WIDTH-1:0] word,
    output logic                word_ready
);

    localparam int         BPW      = bytes_per_word(NB_WIDTH, NB_BYTE);
    localparam logic [1:0] LAST_IDX = 2'(BPW - 1);

    logic [1:0] byte_idx;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[NB_WIDTH-NB_BYTE-1:0], byte_in};
            byte_idx <= (byte_idx == LAST_IDX) ? 2'd0 : byte_idx + 2'd1;
        end
    end

    // Asserted in the same cycle as the handshake of the last byte, so the
    // controller can enter its write state on the following edge.
    assign word_ready = shift_en && (byte_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program from a UART byte stream into instruction memory and muxes the port.
// Latency: memory write one cycle after the 4th byte handshake; sustained 4 bytes per 5 cycles.
// Backpressure: o_rx_ready only in RECV; deasserted during the write cycle and outside a load.
// Ports: i_clk/i_reset (sync, active-high); i_start; i_rx_data/i_rx_valid/o_rx_ready byte stream;
//        i_pc/i_pc_read_enable fetch request; o_mem_* memory port; o_busy, o_load_done, o_overflow,
//        o_word_count, o_checksum status. Option macro: IMEM_LOADER_CHECKSUM_EN builds the XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                  PC_WIDTH  = 9,
    parameter int                  NB_WIDTH  = 32,
    parameter int                  NB_BYTE   = 8,
    parameter logic [NB_WIDTH-1:0] HALT_WORD = NB_WIDTH'(HALT_WORD_DEFAULT)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_rx_ready,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_pc_read_enable,
    output logic [PC_WIDTH-1:0] o_mem_address,
    output logic [NB_WIDTH-1:0] o_mem_write_data,
    output logic                o_mem_write_enable,
    output logic                o_mem_read_enable,
    output logic                o_busy,
    output logic                o_load_done,
    output logic                o_overflow,
    output logic [PC_WIDTH:0]   o_word_count,
    output logic [NB_BYTE-1:0]  o_checksum
);

    // word_count value meaning "every address has been written"
    localparam logic [PC_WIDTH:0] FULL_COUNT = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [PC_WIDTH:0] ONE        = {{PC_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [PC_WIDTH:0]     word_count;
    logic [PC_WIDTH:0]     word_count_inc;
    logic                  overflow;
    logic                  set_overflow;
    logic                  accept;
    logic                  start_load;
    logic                  word_ready;
    logic [NB_WIDTH-1:0]   word;

    // Handshake qualified by registered state only; i_rx_valid never reaches the port mux.
    assign accept         = (state == ST_RECV) && i_rx_valid;
    assign start_load     = i_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign word_count_inc = word_count + ONE;

    byte_assembler #(
        .NB_WIDTH (NB_WIDTH),
        .NB_BYTE  (NB_BYTE)
    ) u_byte_assembler (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (start_load),
        .shift_en   (accept),
        .byte_in    (i_rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        o_rx_ready         = 1'b0;
        o_mem_write_enable = 1'b0;
        o_mem_read_enable  = 1'b0;
        o_busy             = 1'b0;
        o_mem_address      = i_pc;
        set_overflow       = 1'b0;
        case (state)
            ST_IDLE: begin
                o_mem_read_enable = i_pc_read_enable;
                if (i_start) state_next = ST_RECV;
            end
            ST_RECV: begin
                o_rx_ready    = 1'b1;
                o_busy        = 1'b1;
                o_mem_address = word_count[PC_WIDTH-1:0];
                if (word_ready) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                o_busy             = 1'b1;
                o_mem_write_enable = 1'b1;
                o_mem_address      = word_count[PC_WIDTH-1:0];
                // HALT wins when it also happens to fill the last address:
                // the program ended cleanly, so no overflow is flagged.
                if (word == HALT_WORD) begin
                    state_next = ST_DONE;
                end else if (word_count_inc == FULL_COUNT) begin
                    state_next   = ST_DONE;
                    set_overflow = 1'b1;
                end else begin
                    state_next = ST_RECV;
                end
            end
            ST_DONE: begin
                o_mem_read_enable = i_pc_read_enable;
                if (i_start) state_next = ST_RECV;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || start_load) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (state == ST_WRITE) begin
            word_count <= word_count_inc;
            if (set_overflow) overflow <= 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0] checksum;

    always_ff @(posedge i_clk) begin
        if (i_reset || start_load) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ i_rx_data;
        end
    end

    assign o_checksum = checksum;
`else
    assign o_checksum = '0;
`endif

    assign o_mem_write_data = word;
    assign o_load_done      = (state == ST_DONE);
    assign o_overflow       = overflow;
    assign o_word_count     = word_count;

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory load controller for the pipelined MIPS core. Accepts a program as a byte stream from the debug UART receiver and assembles 32-bit words MSB-first. Writes each word to consecutive instruction-memory addresses starting at 0, then stops at the HALT word. Also arbitrates the memory port: the loader owns it while loading, and the pipeline fetch stage (PC) owns it otherwise.

## Interface
- PC_WIDTH, 9, instruction-memory address width (DEPTH = 2**PC_WIDTH words)
- NB_WIDTH, 32, instruction word width
- NB_BYTE, 8, stream byte width
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker
- i_clk  in  1  single clock, all logic on posedge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse, begins a load
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  byte valid
- o_rx_ready  out  1  loader can accept a byte
- i_pc  in  PC_WIDTH  fetch address from pipeline
- i_pc_read_enable  in  1  fetch read request from pipeline
- o_mem_address  out  PC_WIDTH  to instruction memory i_address
- o_mem_write_data  out  NB_WIDTH  to instruction memory write_register
- o_mem_write_enable  out  1  to instruction memory i_write_enable
- o_mem_read_enable  out  1  to instruction memory i_read_enable
- o_busy  out  1  loader owns memory port; pipeline must stall
- o_load_done  out  1  level, program loaded
- o_overflow  out  1  level, memory filled without HALT_WORD
- o_word_count  out  PC_WIDTH+1  words written in current/last load
- o_checksum  out  NB_BYTE  XOR of accepted bytes (see Configuration)

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: o_rx_ready=0. Pipeline owns the port. i_start: clear word_count, byte index, and checksum, then go to RECV.
- RECV: o_rx_ready=1. A byte is accepted when i_rx_valid & o_rx_ready. It is shifted into the word MSB-first: the first byte becomes bits [31:24]. The 4th accepted byte moves to WRITE.
- WRITE: one cycle. o_mem_write_enable=1, o_mem_address=word_count[PC_WIDTH-1:0], o_mem_write_data=assembled word, o_rx_ready=0. word_count increments. Next state:
  - DONE if word == HALT_WORD. The HALT word is written to memory.
  - DONE with o_overflow=1 if word_count reaches DEPTH.
  - RECV otherwise.
- DONE: o_load_done=1, o_rx_ready=0. Bytes are ignored. Pipeline owns the port. i_start restarts the load (→RECV) and clears o_load_done and o_overflow.
- i_start is ignored in RECV and WRITE.
- Port mux:
  - RECV/WRITE: o_mem_read_enable=0, o_busy=1. o_mem_address is word_count when not writing.
  - IDLE/DONE: o_mem_address=i_pc, o_mem_read_enable=i_pc_read_enable, o_mem_write_enable=0, o_busy=0.
- A partial word (fewer than 4 bytes) is never written.

## Timing
- Reset (synchronous): state IDLE; o_rx_ready=0, o_mem_write_enable=0, o_busy=0, o_load_done=0, o_overflow=0, o_word_count=0, o_checksum=0, and the byte shift register is cleared. o_mem_address and o_mem_read_enable follow the IDLE mux combinationally.
- A reset in mid-load aborts the load. Words already written stay in memory; o_load_done stays 0.
- Latency: the write occurs one cycle after the 4th byte handshake.
- Maximum sustained rate: 4 bytes per 5 cycles.
- i_start to first possible byte accept: 1 cycle (RECV in the cycle after the pulse).
- o_busy and the port mux are decoded from registered state, with no combinational path from i_rx_valid.
- o_word_count is registered and updates in the cycle after WRITE.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: o_checksum accumulates the XOR of every accepted byte. It is cleared on i_start and reset, and holds in DONE.
- IMEM_LOADER_CHECKSUM_EN undefined: the accumulator is not built and o_checksum is tied to 0.

## Structure
- Package imem_loader_pkg holds:
  - state encoding localparams (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3)
  - HALT_WORD default
  - BYTES_PER_WORD = NB_WIDTH/NB_BYTE
- Sub-module byte_assembler holds the shift register, 2-bit byte index, clear and shift-enable inputs, and a word_ready pulse. The controller FSM and port mux stay in imem_loader.

## Test plan
- Reset then idle, i_pc=9'd5, i_pc_read_enable=1 → o_mem_address=5, o_mem_read_enable=1, o_busy=0, o_rx_ready=0.
- i_start, then bytes 12 34 56 78, FF FF FF FF → two write pulses: addr 0 data 32'h12345678, addr 1 data 32'hFFFFFFFF; o_load_done=1, o_word_count=2, o_overflow=0.
- i_rx_valid toggling every other cycle during a load → the same words are written; no byte is accepted while in WRITE.
- PC_WIDTH=2, 16 non-HALT bytes → 4 writes to addresses 0–3, then DONE with o_overflow=1. A 17th byte gets no ready.
- Reset after 6 bytes → IDLE, no write for the partial word, o_word_count=0, o_load_done=0. A following i_start reloads from address 0.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01 02 04 08 FF FF FF FF → o_checksum=8'h0F. Without the macro, o_checksum=0.
